// File: rtl/rom_access_arbiter_pkg.sv
// Shared definitions for the ROM access arbiter: FSM state encoding, requester port
// indices and default geometry of the password/question ROM.
package rom_access_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StDeliver = 2'd2
  } arb_state_e;

  // Requester port indices
  localparam logic PortAuth = 1'b0;
  localparam logic PortGame = 1'b1;

  // Default ROM geometry
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefDataW  = 4;
  localparam int unsigned DefRomLat = 2;

endpackage

// File: rtl/rom_access_arbiter_rr_pick2.sv
// Combinational two-requester round-robin picker.
// Ports:
//   e0_i, e1_i     effective requests of port 0 / port 1
//   last_served_i  port index served most recently
//   found_o        at least one request present
//   pick_o         selected port index (valid when found_o)
module rr_pick2
  import rom_access_arbiter_pkg::*;
(
  input  logic e0_i,
  input  logic e1_i,
  input  logic last_served_i,
  output logic found_o,
  output logic pick_o
);

  always_comb begin
    found_o = e0_i | e1_i;
    if (e0_i && e1_i) begin
      // On a tie the port that was not served last wins.
      pick_o = (last_served_i == PortGame) ? PortAuth : PortGame;
    end else if (e1_i) begin
      pick_o = PortGame;
    end else begin
      pick_o = PortAuth;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous ROM between the authentication port (0) and the game port (1).
// Requests are serialised round-robin; each read takes RomLat wait cycles plus one
// deliver cycle and returns data with a one-cycle valid strobe on the requesting port.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   logged_in_i              session status; 0 masks port 1 requests
//   req0_i/addr0_i           port 0 level request and address (sampled at grant)
//   req1_i/addr1_i           port 1 level request and address (sampled at grant)
//   rom_data_i               ROM read data
//   rom_addr_o               registered ROM address
//   grant0_o/grant1_o        one-cycle request-accepted pulse
//   valid0_o/valid1_o        one-cycle pulse: data_o holds this port's word
//   data_o                   registered read data shared by both ports
//   busy_o                   transaction in progress (WAIT or DELIVER)
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int unsigned AddrW  = DefAddrW,
  parameter int unsigned DataW  = DefDataW,
  parameter int unsigned RomLat = DefRomLat
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             logged_in_i,
  input  logic             req0_i,
  input  logic [AddrW-1:0] addr0_i,
  input  logic             req1_i,
  input  logic [AddrW-1:0] addr1_i,
  input  logic [DataW-1:0] rom_data_i,
  output logic [AddrW-1:0] rom_addr_o,
  output logic             grant0_o,
  output logic             grant1_o,
  output logic             valid0_o,
  output logic             valid1_o,
  output logic [DataW-1:0] data_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(RomLat) + 1;
  localparam logic [CntW-1:0] LatLast = CntW'(RomLat - 1);

  arb_state_e       state_q, state_d;
  logic [AddrW-1:0] rom_addr_q, rom_addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [CntW-1:0]  lat_cnt_q, lat_cnt_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;

  logic e0, e1, found, pick;

  // The valid mask stops a still-held request from being re-granted in the cycle its
  // data is being returned.
  assign e0 = req0_i & ~valid0_q;
  assign e1 = req1_i & logged_in_i & ~valid1_q;

  rr_pick2 u_pick (
    .e0_i          (e0),
    .e1_i          (e1),
    .last_served_i (last_q),
    .found_o       (found),
    .pick_o        (pick)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    grant0_d   = 1'b0;
    grant1_d   = 1'b0;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    lat_cnt_d  = lat_cnt_q;
    sel_d      = sel_q;
    last_d     = last_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          sel_d      = pick;
          rom_addr_d = (pick == PortGame) ? addr1_i : addr0_i;
          grant0_d   = (pick == PortAuth);
          grant1_d   = (pick == PortGame);
          lat_cnt_d  = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LatLast) begin
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        data_d   = rom_data_i;
        valid0_d = (sel_q == PortAuth);
        valid1_d = (sel_q == PortGame);
        last_d   = sel_q;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      data_q     <= '0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      lat_cnt_q  <= '0;
      sel_q      <= PortAuth;
      last_q     <= PortGame;  // port 0 wins the first tie
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      lat_cnt_q  <= lat_cnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign data_o     = data_q;
  assign grant0_o   = grant0_q;
  assign grant1_o   = grant1_q;
  assign valid0_o   = valid0_q;
  assign valid1_o   = valid1_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter. The ROM is modelled with a two-stage read
// pipeline holding word(a) = a[3:0] ^ 4'hC; expected values below are hand-computed.
module tb_rom_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       logged_in = 1'b0;
  logic       req0 = 1'b0;
  logic [4:0] addr0 = '0;
  logic       req1 = 1'b0;
  logic [4:0] addr1 = '0;
  logic [3:0] rom_data;
  logic [4:0] rom_addr;
  logic       grant0, grant1, valid0, valid1, busy;
  logic [3:0] data;

  logic [3:0] rom_s1 = '0;
  logic [3:0] rom_s2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_s1 <= rom_addr[3:0] ^ 4'hC;
    rom_s2 <= rom_s1;
  end
  assign rom_data = rom_s2;

  rom_access_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .logged_in_i (logged_in),
    .req0_i      (req0),
    .addr0_i     (addr0),
    .req1_i      (req1),
    .addr1_i     (addr1),
    .rom_data_i  (rom_data),
    .rom_addr_o  (rom_addr),
    .grant0_o    (grant0),
    .grant1_o    (grant1),
    .valid0_o    (valid0),
    .valid1_o    (valid1),
    .data_o      (data),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks {grant0, grant1, valid0, valid1, busy} as one vector
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, grant0, grant1, valid0, valid1, busy}, {27'd0, exp});
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk_flags("rst_flags", 5'b00000);
    rst_n = 1'b1;
    tick();

    // Single port 0 read, word 5 = 9, not logged in
    req0 = 1'b1; addr0 = 5'd5;
    tick();
    chk_flags("p0_grant", 5'b10001);
    chk("p0_addr", 32'(rom_addr), 32'd5);
    tick();
    chk_flags("p0_wait1", 5'b00001);
    tick();
    chk_flags("p0_deliver", 5'b00001);
    tick();
    chk_flags("p0_valid", 5'b00100);
    chk("p0_data", 32'(data), 32'h9);
    req0 = 1'b0;
    tick();
    chk_flags("p0_after", 5'b00000);

    // Reset during WAIT aborts the transaction
    req0 = 1'b1; addr0 = 5'd9;
    tick();
    chk_flags("ab_grant", 5'b10001);
    tick();
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk_flags("ab_async", 5'b00000);
    chk("ab_addr", 32'(rom_addr), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_flags("ab_quiet", 5'b00000);
    end
    req0 = 1'b1; addr0 = 5'd2;
    tick();
    chk_flags("ab_regrant", 5'b10001);
    tick();
    tick();
    tick();
    chk_flags("ab_valid", 5'b00100);
    chk("ab_data", 32'(data), 32'hE);
    req0 = 1'b0;
    tick();

    // Port 1 locked out while logged out
    req1 = 1'b1; addr1 = 5'd6;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_flags("lock_none", 5'b00000);
    end
    logged_in = 1'b1;
    tick();
    chk_flags("p1_grant", 5'b01001);
    chk("p1_addr", 32'(rom_addr), 32'd6);
    tick();
    tick();
    chk_flags("p1_deliver", 5'b00001);
    tick();
    chk_flags("p1_valid", 5'b00010);
    chk("p1_data", 32'(data), 32'hA);
    req1 = 1'b0;
    tick();

    // Both ports held: last served was 1, so order 0,1,0,1 back to back
    req0 = 1'b1; addr0 = 5'd1;
    req1 = 1'b1; addr1 = 5'd2;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk_flags("rr_g0", 5'b10001);
      chk("rr_a0", 32'(rom_addr), 32'd1);
      tick();
      tick();
      tick();
      chk_flags("rr_v0", 5'b00100);
      chk("rr_d0", 32'(data), 32'hD);
      tick();
      chk_flags("rr_g1", 5'b01001);
      chk("rr_a1", 32'(rom_addr), 32'd2);
      tick();
      tick();
      tick();
      chk_flags("rr_v1", 5'b00010);
      chk("rr_d1", 32'(data), 32'hE);
      if (r == 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    tick();
    chk_flags("rr_idle", 5'b00000);

    // Address change after grant is ignored
    req0 = 1'b1; addr0 = 5'd3;
    tick();
    chk_flags("ac_grant", 5'b10001);
    addr0 = 5'd7;
    tick();
    tick();
    tick();
    chk_flags("ac_valid", 5'b00100);
    chk("ac_addr", 32'(rom_addr), 32'd3);
    chk("ac_data", 32'(data), 32'hF);
    req0 = 1'b0;
    tick();

    // Logout during port 1 WAIT: transaction completes, later Req1 ignored
    req1 = 1'b1; addr1 = 5'd4;
    tick();
    chk_flags("lo_grant", 5'b01001);
    logged_in = 1'b0;
    tick();
    tick();
    tick();
    chk_flags("lo_valid", 5'b00010);
    chk("lo_data", 32'(data), 32'h8);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_flags("lo_ignored", 5'b00000);
    end
    req1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares the single synchronous password/question ROM between two requesters: port 0 (authentication, reads password digits) and port 1 (game, reads question operands). Serialises requests with round-robin arbitration and a fixed-latency read sequence, returning data with a one-cycle valid strobe per port. Sits between the requesters and the ROM; the game port is locked out while no user is logged in.

## Interface
- ADDR_W, 5, ROM address width
- DATA_W, 4, ROM data width
- ROM_LAT, 2, ROM read latency in clocks from address change to data stable (≥1)
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- LoggedIn  in  1  session status; 0 masks port 1 requests
- Req0  in  1  port 0 request, level, held until Valid0
- Addr0  in  ADDR_W  port 0 address, sampled at grant
- Req1  in  1  port 1 request, level, held until Valid1
- Addr1  in  ADDR_W  port 1 address, sampled at grant
- RomData  in  DATA_W  ROM read data
- RomAddress  out  ADDR_W  registered ROM address
- Grant0, Grant1  out  1  one-cycle pulse: request accepted
- Valid0, Valid1  out  1  one-cycle pulse: DataOut holds this port's word
- DataOut  out  DATA_W  registered read data, shared by both ports
- Busy  out  1  high in WAIT and DELIVER

## Operation
- States: IDLE, WAIT, DELIVER.
- IDLE: effective requests E0 = Req0 & ~Valid0; E1 = Req1 & LoggedIn & ~Valid1. If none, stay. If one, select it. If both, select the port not equal to LastServed.
- On selection: RomAddress <= selected Addr, Grant<sel> <= 1, Sel <= port, LatCnt <= 0, go WAIT.
- WAIT: LatCnt increments each clock; when LatCnt == ROM_LAT-1, go DELIVER.
- DELIVER: DataOut <= RomData, Valid<Sel> <= 1, LastServed <= Sel, go IDLE.
- Grant and Valid outputs default to 0 every clock unless set as above.
- Addresses changing after grant are ignored; RomAddress holds until the next grant.
- LoggedIn falling during a port 1 transaction: transaction completes, Valid1 still pulses.
- Requester dropping Req mid-transaction: transaction completes, Valid still pulses (requester discards).
- Reset values: state IDLE, RomAddress 0, DataOut 0, Grant0/1 0, Valid0/1 0, Busy 0, LatCnt 0, Sel 0, LastServed 1 (port 0 wins first tie).
- Reset asserted mid-transaction: immediate abort, all outputs to reset values, no Valid issued.
- LatCnt width: $clog2(ROM_LAT)+1, no wrap within a transaction.

## Timing
- Request sampled at edge e0 (IDLE): Grant high and RomAddress updated in cycle after e0.
- WAIT occupies ROM_LAT cycles; DELIVER one cycle; Valid high in cycle after edge e0+ROM_LAT+1 (default: 3 cycles after sampling edge).
- Throughput: one read per ROM_LAT+2 cycles; back-to-back grant possible in the IDLE cycle where Valid is high (the other port, or the same port with a new Req after deassertion is not required — the Valid mask prevents a stale re-grant that cycle).
- Busy = 1 exactly from the cycle after grant through DELIVER.

## Structure
- Shared package: state encodings (IDLE/WAIT/DELIVER), port index constants (PORT_AUTH=0, PORT_GAME=1), default ADDR_W/DATA_W/ROM_LAT.
- One sub-module: rr_pick2 — combinational two-requester round-robin picker (inputs E0, E1, LastServed; outputs Found, Pick).
- FSM, latency counter and output registers inline in rom_access_arbiter.

## Test plan
- Reset low for 2 cycles mid-WAIT -> all outputs 0, no Valid after release; next Req0 served normally.
- Req0=1, Addr0=5, ROM word 5 = 4'h9, LoggedIn=0 -> Grant0 cycle 1, RomAddress=5, Valid0 cycle 3 with DataOut=9.
- LoggedIn=0, Req1=1 held 20 cycles -> no Grant1; raise LoggedIn -> Grant1 next cycle, Valid1 3 cycles after sampling.
- LoggedIn=1, Req0 and Req1 both held continuously -> grants alternate 0,1,0,1; each Valid carries its own address's word.
- Addr0 changed from 3 to 7 the cycle after Grant0 -> RomAddress stays 3, DataOut = word 3.
- LoggedIn falls during port 1 WAIT -> Valid1 still pulses with correct data; subsequent Req1 ignored.
